exec_stage: RTL
===============

EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 Parameter: MUL_CYCLES, 4, number of cycles mul_stall is held high for one multiply (legal range 2..32).
REQ-002 clock  in  1  sole clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 icache_stall, dcache_stall  in  1 each  stalls from fetch and memory stages.
REQ-005 da_pc  in  32  PC of the decoded instruction.
REQ-006 da_write_sel  in  5  destination register.
REQ-007 da_op1, da_op2  in  32 each  ALU operands.
REQ-008 da_data2  in  32  store data; forwarded unchanged.
REQ-009 da_alu_op  in  4  operation code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL; 11..15 yield 0.
REQ-010 da_is_load, da_is_store, da_is_wb  in  1 each  instruction class flags.
REQ-011 ac_pc, ac_write_sel, ac_alu_result, ac_data2  out  32/5/32/32  registered outputs to the memory stage.
REQ-012 ac_is_load, ac_is_store, ac_is_wb  out  1 each  registered flags.
REQ-013 mul_stall  out  1  high while a multiply is incomplete; freezes every pipeline stage.

Function
REQ-014 Shifts use da_op2[4:0] only; SRA sign-extends; SLT is signed; SLTU is unsigned; results are 32 bits, wrap on overflow.
REQ-015 MUL returns the low 32 bits of da_op1*da_op2.
REQ-016 Output register loads all ac_* from da_*/result on posedge iff icache_stall, dcache_stall and mul_stall are all 0; it otherwise holds.
REQ-017 Multiplier FSM states: IDLE, BUSY, DONE.
REQ-018 IDLE: mul_stall = (da_alu_op==10), combinational; if so, the FSM latches operands, loads its counter with MUL_CYCLES-1, and enters BUSY.
REQ-019 BUSY: mul_stall=1; counter decrements each cycle; on counter==1 the product is stored and the FSM enters DONE.
REQ-020 DONE: mul_stall=0; the product drives ac_alu_result input; the FSM returns to IDLE only on a cycle with no icache/dcache stall; under those stalls, it holds DONE.
REQ-021 Multiplier counter advances regardless of icache_stall/dcache_stall.
REQ-022 Total mul_stall high cycles per multiply = MUL_CYCLES exactly, in the absence of reset.
REQ-023 Back-to-back MULs: the second begins in IDLE on the cycle after the first leaves DONE.

Reset
REQ-024 reset=1 on posedge: all ac_* outputs become 0, FSM goes to IDLE, counter becomes 0, and the latched operands/product become 0.
REQ-025 Reset during BUSY or DONE aborts the multiply; mul_stall is then purely combinational from IDLE on the next cycle.
REQ-026 Reset overrides all stalls.

Configuration
REQ-027 Macro EXEC_MUL_MULTICYCLE_EN defined: the multi-cycle FSM of REQ-017..023 is compiled in.
REQ-028 Macro undefined: MUL is computed combinationally in one cycle, the FSM is absent, mul_stall is tied 0, and MUL_CYCLES is ignored.

Verification
REQ-029 Reset: assert reset with da_* nonzero -> every ac_* is 0 and mul_stall is 0 after the edge.
REQ-030 ALU: op1=0xFFFFFFF0, op2=0x00000004; SRA -> 0xFFFFFFFF; SRL -> 0x0FFFFFFF; SLT -> 1; SLTU -> 0; ADD -> 0xFFFFFFF4.
REQ-031 MUL with MUL_CYCLES=4, op1=7, op2=-3 -> mul_stall high for 4 cycles; ac_alu_result=0xFFFFFFEB on the next edge.
REQ-032 dcache_stall=1 for 3 cycles while in DONE -> FSM holds, mul_stall stays 0, ac_* are unchanged; after release, ac_alu_result=product.
REQ-033 Reset asserted in the 2nd BUSY cycle -> outputs are 0, FSM is IDLE; reissued MUL 5*6 -> 30 after a full MUL_CYCLES stall.
REQ-034 Macro undefined: MUL 0x10000*0x10000 -> ac_alu_result=0 one cycle later, mul_stall is never high.

Source files
------------

// File: rtl/exec_stage.sv
// ============================================================================
// exec_stage
// ----------------------------------------------------------------------------
// Execute stage of a simple in-order pipeline. It evaluates one ALU operation
// per instruction and registers the result, together with the instruction's
// bookkeeping fields, toward the memory stage.
//
// Configuration macro: EXEC_MUL_MULTICYCLE_EN
//   defined   : MUL runs on an iterative multiplier controlled by a small FSM
//               (IDLE -> BUSY -> DONE). mul_stall is raised for exactly
//               MUL_CYCLES cycles per multiply and freezes the whole pipeline.
//   undefined : MUL is a single-cycle combinational multiply, mul_stall is
//               tied low, and MUL_CYCLES has no effect.
//
// Parameters
//   MUL_CYCLES     cycles mul_stall stays high per multiply (legal 2..32)
//
// Ports
//   clock          sole clock, all state updates on the rising edge
//   reset          synchronous, active-high; overrides every stall
//   icache_stall   fetch-side stall, freezes the output register
//   dcache_stall   memory-side stall, freezes the output register
//   da_pc          PC of the decoded instruction
//   da_write_sel   destination register index
//   da_op1/op2     ALU operands
//   da_data2       store data, passed through unchanged
//   da_alu_op      0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA,
//                  8 SLT, 9 SLTU, 10 MUL, 11..15 produce 0
//   da_is_load/da_is_store/da_is_wb   instruction class flags
//   ac_*           registered copies of the above toward the memory stage
//   mul_stall      high while a multiply is still in progress
// ============================================================================
module exec_stage #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        icache_stall,
    input  logic        dcache_stall,
    input  logic [31:0] da_pc,
    input  logic [4:0]  da_write_sel,
    input  logic [31:0] da_op1,
    input  logic [31:0] da_op2,
    input  logic [31:0] da_data2,
    input  logic [3:0]  da_alu_op,
    input  logic        da_is_load,
    input  logic        da_is_store,
    input  logic        da_is_wb,
    output logic [31:0] ac_pc,
    output logic [4:0]  ac_write_sel,
    output logic [31:0] ac_alu_result,
    output logic [31:0] ac_data2,
    output logic        ac_is_load,
    output logic        ac_is_store,
    output logic        ac_is_wb,
    output logic        mul_stall
);

    // ------------------------------------------------------------------------
    // Operation codes
    // ------------------------------------------------------------------------
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    logic [31:0] alu_result;
    logic [31:0] mul_result;
    logic [4:0]  shamt;
    logic        is_mul;
    logic        pipe_advance;

    // Shift amounts use only the low five bits of op2.
    assign shamt  = da_op2[4:0];
    assign is_mul = (da_alu_op == OP_MUL);

`ifdef EXEC_MUL_MULTICYCLE_EN
    // ------------------------------------------------------------------------
    // Multi-cycle multiplier
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_BUSY,
        MUL_DONE
    } mul_state_t;

    // Counter holds MUL_CYCLES-1 at most; keep it at least one bit wide.
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    mul_state_t        state;
    mul_state_t        next_state;
    logic [CNT_W-1:0]  mul_count;
    logic [31:0]       mul_a;
    logic [31:0]       mul_b;
    logic [31:0]       mul_product;
    logic              mem_stall;

    assign mem_stall = icache_stall | dcache_stall;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= MUL_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. The counter runs independently of cache stalls, but
    // leaving DONE waits until the result can actually be captured downstream.
    always_comb begin
        next_state = state;
        case (state)
            MUL_IDLE: if (is_mul)                     next_state = MUL_BUSY;
            MUL_BUSY: if (mul_count == CNT_W'(1))     next_state = MUL_DONE;
            MUL_DONE: if (!mem_stall)                 next_state = MUL_IDLE;
            default:                                  next_state = MUL_IDLE;
        endcase
    end

    // Output logic. In IDLE the stall is raised combinationally on the very
    // cycle a MUL is presented, so the IDLE cycle plus MUL_CYCLES-1 BUSY
    // cycles add up to exactly MUL_CYCLES stall cycles.
    always_comb begin
        mul_stall = 1'b0;
        case (state)
            MUL_IDLE: mul_stall = is_mul;
            MUL_BUSY: mul_stall = 1'b1;
            MUL_DONE: mul_stall = 1'b0;
            default:  mul_stall = 1'b0;
        endcase
    end

    // Multiplier datapath: operand capture, countdown, product capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            mul_count   <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_product <= '0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (is_mul) begin
                        mul_a     <= da_op1;
                        mul_b     <= da_op2;
                        mul_count <= CNT_W'(MUL_CYCLES - 1);
                    end
                end
                MUL_BUSY: begin
                    mul_count <= mul_count - CNT_W'(1);
                    if (mul_count == CNT_W'(1)) begin
                        mul_product <= mul_a * mul_b;
                    end
                end
                default: ;
            endcase
        end
    end

    // Only reaches the output register from DONE; in IDLE/BUSY mul_stall
    // blocks the load so the stale product is never captured.
    assign mul_result = mul_product;
`else
    // ------------------------------------------------------------------------
    // Single-cycle multiplier: low 32 bits of the product, no stall.
    // ------------------------------------------------------------------------
    logic unused_mul_cycles;

    assign mul_result        = da_op1 * da_op2;
    assign mul_stall         = 1'b0;
    assign unused_mul_cycles = (MUL_CYCLES != 0);
`endif

    // ------------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------------
    // NOTE: the default assignment ahead of the case keeps every path driven,
    // so no latch is inferred for codes 11..15 or future additions.
    always_comb begin
        alu_result = '0;
        case (da_alu_op)
            OP_ADD:  alu_result = da_op1 + da_op2;
            OP_SUB:  alu_result = da_op1 - da_op2;
            OP_AND:  alu_result = da_op1 & da_op2;
            OP_OR:   alu_result = da_op1 | da_op2;
            OP_XOR:  alu_result = da_op1 ^ da_op2;
            OP_SLL:  alu_result = da_op1 << shamt;
            OP_SRL:  alu_result = da_op1 >> shamt;
            OP_SRA:  alu_result = $unsigned($signed(da_op1) >>> shamt);
            OP_SLT:  alu_result = {31'd0, ($signed(da_op1) < $signed(da_op2))};
            OP_SLTU: alu_result = {31'd0, (da_op1 < da_op2)};
            OP_MUL:  alu_result = mul_result;
            default: alu_result = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output register toward the memory stage
    // ------------------------------------------------------------------------
    assign pipe_advance = !icache_stall && !dcache_stall && !mul_stall;

    always_ff @(posedge clock) begin
        if (reset) begin
            ac_pc         <= '0;
            ac_write_sel  <= '0;
            ac_alu_result <= '0;
            ac_data2      <= '0;
            ac_is_load    <= 1'b0;
            ac_is_store   <= 1'b0;
            ac_is_wb      <= 1'b0;
        end else if (pipe_advance) begin
            ac_pc         <= da_pc;
            ac_write_sel  <= da_write_sel;
            ac_alu_result <= alu_result;
            ac_data2      <= da_data2;
            ac_is_load    <= da_is_load;
            ac_is_store   <= da_is_store;
            ac_is_wb      <= da_is_wb;
        end
    end

endmodule
